// File: rtl/alsu_driver_if.sv
// Request, response and ALSU pin bundle for alsu_driver.
// master = driver side, slave = requester/ALSU environment side.
interface alsu_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_opcode;
  logic [2:0]  req_a;
  logic [2:0]  req_b;
  logic [2:0]  req_count;
  logic        req_cin;
  logic        req_serial_in;
  logic        req_direction;
  logic        req_red_op_a;
  logic        req_red_op_b;
  logic        req_bypass_a;
  logic        req_bypass_b;

  logic [2:0]  alsu_A;
  logic [2:0]  alsu_B;
  logic [2:0]  alsu_opcode;
  logic        alsu_cin;
  logic        alsu_serial_in;
  logic        alsu_direction;
  logic        alsu_red_op_A;
  logic        alsu_red_op_B;
  logic        alsu_bypass_A;
  logic        alsu_bypass_B;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_out;
  logic        rsp_invalid;
  logic [2:0]  rsp_opcode;

  modport master (
    input  req_valid, req_opcode, req_a, req_b, req_count, req_cin, req_serial_in,
           req_direction, req_red_op_a, req_red_op_b, req_bypass_a, req_bypass_b,
           alsu_out, alsu_leds, rsp_ready,
    output req_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
           rsp_valid, rsp_out, rsp_invalid, rsp_opcode
  );

  modport slave (
    output req_valid, req_opcode, req_a, req_b, req_count, req_cin, req_serial_in,
           req_direction, req_red_op_a, req_red_op_b, req_bypass_a, req_bypass_b,
           alsu_out, alsu_leds, rsp_ready,
    input  req_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
           rsp_valid, rsp_out, rsp_invalid, rsp_opcode
  );
endinterface

// File: rtl/alsu_driver.sv
// Single-transaction ALSU command initiator: latches a request, sequences the ALSU
// pins (optional seed, then cnt issue cycles), captures out/leds at the pipeline delay.
module alsu_driver #(
  parameter int unsigned LATENCY    = 2,
  parameter bit          SEED_SHIFT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  alsu_driver_if.master bus
);
  localparam int unsigned CNT_W = (LATENCY > 7) ? $clog2(LATENCY + 1) : 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } cmd_t;

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [5:0]         rsp_out_q, rsp_out_d;
  logic               rsp_invalid_q, rsp_invalid_d;
  logic [2:0]         rsp_opcode_q, rsp_opcode_d;
  logic               req_is_shift;
  logic               first_issue;

  assign req_is_shift = (bus.req_opcode[2:1] == 2'b10);
  assign first_issue  = first_q && (state_q == S_ISSUE);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b0;
      pipe_q        <= '0;
      rsp_out_q     <= '0;
      rsp_invalid_q <= 1'b0;
      rsp_opcode_q  <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      pipe_q        <= pipe_d;
      rsp_out_q     <= rsp_out_d;
      rsp_invalid_q <= rsp_invalid_d;
      rsp_opcode_q  <= rsp_opcode_d;
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    rsp_out_d     = rsp_out_q;
    rsp_invalid_d = rsp_invalid_q;
    rsp_opcode_d  = rsp_opcode_q;
    // First-issue strobe delayed to the cycle where leds reflects that command
    pipe_d        = LATENCY'({pipe_q, first_issue});
    if (pipe_q[LATENCY-1]) begin
      rsp_invalid_d = (bus.alsu_leds != 16'd0);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cmd_d.opcode    = bus.req_opcode;
          cmd_d.a         = bus.req_a;
          cmd_d.b         = bus.req_b;
          cmd_d.cin       = bus.req_cin;
          cmd_d.serial_in = bus.req_serial_in;
          cmd_d.direction = bus.req_direction;
          cmd_d.red_op_a  = bus.req_red_op_a;
          cmd_d.red_op_b  = bus.req_red_op_b;
          cmd_d.bypass_a  = bus.req_bypass_a;
          cmd_d.bypass_b  = bus.req_bypass_b;
          cnt_d   = (req_is_shift && (bus.req_count != 3'd0)) ? CNT_W'(bus.req_count) : CNT_W'(1);
          first_d = 1'b1;
          state_d = (req_is_shift && SEED_SHIFT) ? S_SEED : S_ISSUE;
        end
      end
      S_SEED: state_d = S_ISSUE;
      S_ISSUE: begin
        first_d = 1'b0;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = CNT_W'(LATENCY);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_out_d    = bus.alsu_out;
          rsp_opcode_d = cmd_q.opcode;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin and handshake decode; idle command unless seeding or issuing
  always_comb begin
    bus.req_ready      = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.alsu_A         = 3'd0;
    bus.alsu_B         = 3'd0;
    bus.alsu_opcode    = 3'd0;
    bus.alsu_cin       = 1'b0;
    bus.alsu_serial_in = 1'b0;
    bus.alsu_direction = 1'b0;
    bus.alsu_red_op_A  = 1'b0;
    bus.alsu_red_op_B  = 1'b0;
    bus.alsu_bypass_A  = 1'b0;
    bus.alsu_bypass_B  = 1'b0;
    case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_SEED: begin
        bus.alsu_bypass_A = 1'b1;
        bus.alsu_A        = cmd_q.a;
        bus.alsu_opcode   = cmd_q.opcode;
      end
      S_ISSUE: begin
        bus.alsu_A         = cmd_q.a;
        bus.alsu_B         = cmd_q.b;
        bus.alsu_opcode    = cmd_q.opcode;
        bus.alsu_cin       = cmd_q.cin;
        bus.alsu_serial_in = cmd_q.serial_in;
        bus.alsu_direction = cmd_q.direction;
        bus.alsu_red_op_A  = cmd_q.red_op_a;
        bus.alsu_red_op_B  = cmd_q.red_op_b;
        bus.alsu_bypass_A  = cmd_q.bypass_a;
        bus.alsu_bypass_B  = cmd_q.bypass_b;
      end
      S_RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_out     = rsp_out_q;
  assign bus.rsp_invalid = rsp_invalid_q;
  assign bus.rsp_opcode  = rsp_opcode_q;

endmodule

// File: tb/tb_alsu_driver.sv
// Bench for alsu_driver: a behavioural two-stage ALSU plant on the pins, and expected
// responses computed from operation rules (seed, repeat count, latency formula).
module tb_alsu_driver;
  localparam int unsigned LATENCY = 2;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] count;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_a;
    logic       red_b;
    logic       byp_a;
    logic       byp_b;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alsu_driver_if bus ();
  alsu_driver #(.LATENCY(LATENCY), .SEED_SHIFT(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic is_invalid(input req_t c);
    return (c.opcode >= 3'd6) || ((c.red_a || c.red_b) && (c.opcode >= 3'd2));
  endfunction

  // One ALSU evaluation of command c against the current output o
  function automatic logic [5:0] alsu_op(input logic [5:0] o, input req_t c);
    if (c.byp_a) return {3'b000, c.a};
    if (c.byp_b) return {3'b000, c.b};
    if (is_invalid(c)) return 6'd0;
    case (c.opcode)
      3'd0: return c.red_a ? {5'd0, |c.a} : (c.red_b ? {5'd0, |c.b} : {3'd0, c.a | c.b});
      3'd1: return c.red_a ? {5'd0, ^c.a} : (c.red_b ? {5'd0, ^c.b} : {3'd0, c.a ^ c.b});
      3'd2: return 6'(c.a) + 6'(c.b) + 6'(c.cin);
      3'd3: return 6'(c.a) * 6'(c.b);
      3'd4: return c.direction ? {o[4:0], c.serial_in} : {c.serial_in, o[5:1]};
      3'd5: return c.direction ? {o[4:0], o[5]} : {o[0], o[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  function automatic int ref_repeats(input req_t r);
    if (r.opcode == 3'd4 || r.opcode == 3'd5) return (r.count == 3'd0) ? 1 : int'(r.count);
    return 1;
  endfunction

  function automatic logic [5:0] ref_result(input req_t r);
    logic [5:0] o;
    o = {3'b000, r.a};
    for (int i = 0; i < ref_repeats(r); i++) o = alsu_op(o, r);
    return o;
  endfunction

  function automatic int ref_latency(input req_t r);
    int seed;
    seed = (r.opcode == 3'd4 || r.opcode == 3'd5) ? 1 : 0;
    return seed + ref_repeats(r) + LATENCY + 1;
  endfunction

  function automatic req_t mk_req(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                  input logic cin, input logic si, input logic dir,
                                  input logic ra, input logic [2:0] cnt);
    req_t r;
    r = '0;
    r.opcode = op; r.a = a; r.b = b; r.cin = cin; r.serial_in = si;
    r.direction = dir; r.red_a = ra; r.count = cnt;
    return r;
  endfunction

  // ALSU plant: input register stage then output/leds register stage
  req_t        pin_c, pin_q;
  logic [5:0]  alsu_out_q;
  logic [15:0] alsu_leds_q;

  always_comb begin
    pin_c           = '0;
    pin_c.opcode    = bus.alsu_opcode;
    pin_c.a         = bus.alsu_A;
    pin_c.b         = bus.alsu_B;
    pin_c.cin       = bus.alsu_cin;
    pin_c.serial_in = bus.alsu_serial_in;
    pin_c.direction = bus.alsu_direction;
    pin_c.red_a     = bus.alsu_red_op_A;
    pin_c.red_b     = bus.alsu_red_op_B;
    pin_c.byp_a     = bus.alsu_bypass_A;
    pin_c.byp_b     = bus.alsu_bypass_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin_q       <= '0;
      alsu_out_q  <= '0;
      alsu_leds_q <= '0;
    end else begin
      pin_q       <= pin_c;
      alsu_out_q  <= alsu_op(alsu_out_q, pin_q);
      alsu_leds_q <= is_invalid(pin_q) ? ~alsu_leds_q : 16'h0000;
    end
  end

  assign bus.alsu_out  = alsu_out_q;
  assign bus.alsu_leds = alsu_leds_q;

  task automatic drive_req(input req_t r);
    bus.req_opcode    = r.opcode;
    bus.req_a         = r.a;
    bus.req_b         = r.b;
    bus.req_count     = r.count;
    bus.req_cin       = r.cin;
    bus.req_serial_in = r.serial_in;
    bus.req_direction = r.direction;
    bus.req_red_op_a  = r.red_a;
    bus.req_red_op_b  = r.red_b;
    bus.req_bypass_a  = r.byp_a;
    bus.req_bypass_b  = r.byp_b;
  endtask

  // Present r at a negedge, return cycles from accept to first rsp_valid sample
  task automatic issue_req(input req_t r, input bit rdy, output int lat, output bit ok);
    int guard;
    bus.rsp_ready = rdy;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    drive_req(r);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    ok = bus.rsp_valid;
  endtask

  task automatic complete_rsp;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    int  lat;
    bit  ok;
    bit  seen;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_out !== 6'd0 || bus.rsp_invalid !== 1'b0 ||
        bus.rsp_opcode !== 3'd0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b out=%0d inv=%b op=%0d ready=%b, want 0/0/0/0/1",
               bus.rsp_valid, bus.rsp_out, bus.rsp_invalid, bus.rsp_opcode, bus.req_ready);
    end
    // Reset in the first WAIT cycle of an OR
    drive_req(mk_req(3'd0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.alsu_opcode !== 3'd0 ||
        bus.alsu_A !== 3'd0 || bus.alsu_B !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: valid=%b ready=%b op=%0d A=%0d B=%0d, want 0/1/0/0/0",
               bus.rsp_valid, bus.req_ready, bus.alsu_opcode, bus.alsu_A, bus.alsu_B);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard_wait: response seen=%b, want 0", seen);
    end
    // Reset while a response is pending
    issue_req(mk_req(3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0, lat, ok);
    n_checks++;
    if (!ok || bus.rsp_out !== 6'd9) begin
      n_fail++;
      $display("FAIL reset_pre_resp: valid=%b out=%0d, want 1/9", ok, bus.rsp_out);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_out !== 6'd0 || bus.rsp_opcode !== 3'd0 ||
        bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_resp: valid=%b out=%0d op=%0d ready=%b, want 0/0/0/1",
               bus.rsp_valid, bus.rsp_out, bus.rsp_opcode, bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard_resp: response seen=%b, want 0", seen);
    end
  endtask

  task automatic test_directed;
    req_t       rq[8];
    logic [5:0] eo[8];
    logic       ei[8];
    int         el[8];
    int         lat;
    bit         ok;
    rq[0] = mk_req(3'd0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); eo[0] = 6'd7;  ei[0] = 1'b0; el[0] = 4;
    rq[1] = mk_req(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0); eo[1] = 6'd6;  ei[1] = 1'b0; el[1] = 4;
    rq[2] = mk_req(3'd4, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3); eo[2] = 6'd31; ei[2] = 1'b0; el[2] = 7;
    rq[3] = mk_req(3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2); eo[3] = 6'd16; ei[3] = 1'b0; el[3] = 6;
    rq[4] = mk_req(3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); eo[4] = 6'd0;  ei[4] = 1'b1; el[4] = 4;
    rq[5] = mk_req(3'd2, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0); eo[5] = 6'd0;  ei[5] = 1'b1; el[5] = 4;
    rq[6] = mk_req(3'd4, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0); eo[6] = 6'd2;  ei[6] = 1'b0; el[6] = 5;
    rq[7] = mk_req(3'd3, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5); eo[7] = 6'd49; ei[7] = 1'b0; el[7] = 4;
    for (int i = 0; i < 8; i++) begin
      issue_req(rq[i], 1'(i % 2), lat, ok);
      n_checks++;
      if (!ok || lat != el[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] latency: got %0d cycles (valid=%b), want %0d", i, lat, ok, el[i]);
      end
      n_checks++;
      if (bus.rsp_out !== eo[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] rsp_out: got %0d, want %0d", i, bus.rsp_out, eo[i]);
      end
      n_checks++;
      if (bus.rsp_invalid !== ei[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] rsp_invalid: got %b, want %b", i, bus.rsp_invalid, ei[i]);
      end
      n_checks++;
      if (bus.rsp_opcode !== rq[i].opcode) begin
        n_fail++;
        $display("FAIL directed[%0d] rsp_opcode: got %0d, want %0d", i, bus.rsp_opcode, rq[i].opcode);
      end
      complete_rsp();
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed[%0d] release: ready=%b valid=%b, want 1/0", i, bus.req_ready, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    bit ok;
    bit seen;
    issue_req(mk_req(3'd1, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0, lat, ok);
    drive_req(mk_req(3'd7, 3'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7));
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_out !== 6'd5 || bus.rsp_invalid !== 1'b0 ||
          bus.rsp_opcode !== 3'd1 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: valid=%b out=%0d inv=%b op=%0d ready=%b, want 1/5/0/1/0",
                 i, bus.rsp_valid, bus.rsp_out, bus.rsp_invalid, bus.rsp_opcode, bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    complete_rsp();
    seen = 1'b0;
    repeat (6) begin
      if (bus.rsp_valid || !bus.req_ready) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_ignored_req: activity seen=%b, want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    req_t r;
    int   lat;
    bit   ok;
    for (int i = 0; i < 40; i++) begin
      r           = '0;
      r.opcode    = 3'($urandom_range(0, 7));
      r.a         = 3'($urandom);
      r.b         = 3'($urandom);
      r.count     = 3'($urandom);
      r.cin       = 1'($urandom);
      r.serial_in = 1'($urandom);
      r.direction = 1'($urandom);
      r.red_a     = ($urandom_range(0, 7) == 0);
      r.red_b     = ($urandom_range(0, 7) == 0);
      r.byp_a     = ($urandom_range(0, 9) == 0);
      r.byp_b     = ($urandom_range(0, 9) == 0);
      issue_req(r, 1'($urandom), lat, ok);
      n_checks++;
      if (!ok || lat != ref_latency(r)) begin
        n_fail++;
        $display("FAIL random[%0d] latency op=%0d: got %0d (valid=%b), want %0d",
                 i, r.opcode, lat, ok, ref_latency(r));
      end
      n_checks++;
      if (bus.rsp_out !== ref_result(r) || bus.rsp_invalid !== is_invalid(r) ||
          bus.rsp_opcode !== r.opcode) begin
        n_fail++;
        $display("FAIL random[%0d] response %h: got out=%0d inv=%b op=%0d, want %0d/%b/%0d",
                 i, r, bus.rsp_out, bus.rsp_invalid, bus.rsp_opcode,
                 ref_result(r), is_invalid(r), r.opcode);
      end
      complete_rsp();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_req('0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
